// File: rtl/cond_logic_ex.sv
// rtl/cond_logic_ex.sv - execute-stage conditional execution: NZCV flags, E->M gating, exec/skip counters
module cond_logic_ex #(
  parameter int         CNT_W       = 16,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ValidE,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic [3:0]       CondE,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagWriteE,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic             PCSrcE,
  input  logic             CntClr,
  output logic [3:0]       Flags,
  output logic             CondExE,
  output logic             PCSrcTakenE,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             PCSrcM,
  output logic [CNT_W-1:0] ExecCnt,
  output logic [CNT_W-1:0] SkipCnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Condition evaluation against the registered flags only; no ALUFlags bypass.
  function automatic logic condcheck(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      4'b0000: condcheck = z;
      4'b0001: condcheck = ~z;
      4'b0010: condcheck = c;
      4'b0011: condcheck = ~c;
      4'b0100: condcheck = n;
      4'b0101: condcheck = ~n;
      4'b0110: condcheck = v;
      4'b0111: condcheck = ~v;
      4'b1000: condcheck = c & ~z;
      4'b1001: condcheck = ~c | z;
      4'b1010: condcheck = ~(n ^ v);
      4'b1011: condcheck = n ^ v;
      4'b1100: condcheck = ~z & ~(n ^ v);
      4'b1101: condcheck = z | (n ^ v);
      default: condcheck = 1'b1;
    endcase
  endfunction

  logic live;
  logic gate;

  assign live        = ValidE & ~FlushE & ~StallE;
  assign CondExE     = condcheck(CondE, Flags);
  assign gate        = live & CondExE;
  assign PCSrcTakenE = PCSrcE & gate;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Flags <= RESET_FLAGS;
    end else if (gate) begin
      if (FlagWriteE[1]) Flags[3:2] <= ALUFlags[3:2];
      if (FlagWriteE[0]) Flags[1:0] <= ALUFlags[1:0];
    end
  end

  // Non-live or failed instructions enter M as a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
      PCSrcM    <= 1'b0;
    end else begin
      RegWriteM <= RegWriteE & gate;
      MemWriteM <= MemWriteE & gate;
      PCSrcM    <= PCSrcE & gate;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ExecCnt <= '0;
      SkipCnt <= '0;
    end else if (CntClr) begin
      ExecCnt <= '0;
      SkipCnt <= '0;
    end else if (live) begin
      if (CondExE) begin
        if (ExecCnt != CNT_MAX) ExecCnt <= ExecCnt + CNT_ONE;
      end else begin
        if (SkipCnt != CNT_MAX) SkipCnt <= SkipCnt + CNT_ONE;
      end
    end
  end

endmodule
